// File: rtl/vga_sync_ctrl.sv
// VGA scan sequencer: steps pixel/line counters on each PixelTick and drives
// registered HSync/VSync/VideoOn plus line and frame start markers.
module vga_sync_ctrl #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       PixelTick,
  output logic       HSync,
  output logic       VSync,
  output logic       VideoOn,
  output logic [9:0] PixelX,
  output logic [9:0] PixelY,
  output logic       LineStart,
  output logic       FrameStart
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_FRONT_AT = 10'(H_ACTIVE);
  localparam logic [9:0] H_SYNC_AT  = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] H_BACK_AT  = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_FRONT_AT = 10'(V_ACTIVE);
  localparam logic [9:0] V_SYNC_AT  = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] V_BACK_AT  = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);

  typedef enum logic [1:0] {H_ACT, H_FRONT, H_SYNCS, H_BACK} hstate_t;
  typedef enum logic [1:0] {V_ACT, V_FRONT, V_SYNCS, V_BACK} vstate_t;

  hstate_t    hState, hNext;
  vstate_t    vState, vNext;
  logic [9:0] xNext, yNext;
  logic       lineWrap, frameWrap;
  logic       hSyncNext, vSyncNext, videoNext;

  // Next counter values; the FSMs and registered outputs all key off these
  always_comb begin
    lineWrap  = PixelTick && (PixelX == H_LAST);
    frameWrap = lineWrap && (PixelY == V_LAST);
    xNext     = PixelX;
    yNext     = PixelY;
    if (PixelTick) begin
      xNext = lineWrap ? 10'd0 : PixelX + 10'd1;
    end
    if (lineWrap) begin
      yNext = frameWrap ? 10'd0 : PixelY + 10'd1;
    end
  end

  always_comb begin
    hNext = hState;
    unique case (hState)
      H_ACT:   if (xNext == H_FRONT_AT) hNext = H_FRONT;
      H_FRONT: if (xNext == H_SYNC_AT)  hNext = H_SYNCS;
      H_SYNCS: if (xNext == H_BACK_AT)  hNext = H_BACK;
      H_BACK:  if (xNext == 10'd0)      hNext = H_ACT;
    endcase
  end

  // yNext only moves on a line wrap, so the vertical FSM steps once per line
  always_comb begin
    vNext = vState;
    unique case (vState)
      V_ACT:   if (yNext == V_FRONT_AT) vNext = V_FRONT;
      V_FRONT: if (yNext == V_SYNC_AT)  vNext = V_SYNCS;
      V_SYNCS: if (yNext == V_BACK_AT)  vNext = V_BACK;
      V_BACK:  if (yNext == 10'd0)      vNext = V_ACT;
    endcase
  end

  always_comb begin
    hSyncNext = (hNext == H_SYNCS) ? SYNC_POL : ~SYNC_POL;
    vSyncNext = (vNext == V_SYNCS) ? SYNC_POL : ~SYNC_POL;
    videoNext = (hNext == H_ACT) && (vNext == V_ACT);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      hState     <= H_ACT;
      vState     <= V_ACT;
      PixelX     <= 10'd0;
      PixelY     <= 10'd0;
      HSync      <= ~SYNC_POL;
      VSync      <= ~SYNC_POL;
      VideoOn    <= 1'b1;
      LineStart  <= 1'b0;
      FrameStart <= 1'b0;
    end else begin
      hState     <= hNext;
      vState     <= vNext;
      PixelX     <= xNext;
      PixelY     <= yNext;
      HSync      <= hSyncNext;
      VSync      <= vSyncNext;
      VideoOn    <= videoNext;
      LineStart  <= lineWrap;
      FrameStart <= frameWrap;
    end
  end

endmodule

// File: tb/tb_vga_sync_ctrl.sv
// Bench for vga_sync_ctrl using a shrunken raster (32 x 21) so whole frames
// fit in a short run; a coordinate model predicts every output each cycle.
module tb_vga_sync_ctrl;

  localparam int HA = 16, HF = 4, HS = 6, HB = 6;
  localparam int VA = 12, VF = 2, VS = 3, VB = 4;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam bit POL = 1'b0;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       PixelTick = 1'b0;
  logic       HSync, VSync, VideoOn, LineStart, FrameStart;
  logic [9:0] PixelX, PixelY;

  int  checks = 0;
  int  errors = 0;
  bit  checkEn = 1'b0;
  int  mx = 0, my = 0;
  bit  expLine = 1'b0, expFrame = 1'b0;
  int  lsCount = 0, fsCount = 0;

  vga_sync_ctrl #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .SYNC_POL(POL)
  ) dut (
    .CLK(CLK), .RST(RST), .PixelTick(PixelTick),
    .HSync(HSync), .VSync(VSync), .VideoOn(VideoOn),
    .PixelX(PixelX), .PixelY(PixelY),
    .LineStart(LineStart), .FrameStart(FrameStart)
  );

  always #5 CLK = ~CLK;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Drive one CLK of PixelTick and advance the coordinate model on a counted tick
  task automatic applyStimulus(input bit t);
    PixelTick = t;
    @(posedge CLK);
    if (t && !RST) begin
      expLine  = (mx == HT - 1);
      expFrame = expLine && (my == VT - 1);
      if (expLine) begin
        mx = 0;
        my = (my == VT - 1) ? 0 : my + 1;
      end else begin
        mx = mx + 1;
      end
    end else begin
      expLine  = 1'b0;
      expFrame = 1'b0;
    end
    @(negedge CLK);
    if (LineStart)  lsCount++;
    if (FrameStart) fsCount++;
  endtask

  task automatic advanceTo(input int tx, input int ty);
    int budget = 4000;
    while (!(int'(PixelX) == tx && int'(PixelY) == ty) && budget > 0) begin
      applyStimulus($urandom_range(0, 3) != 0);
      budget--;
    end
    checkOutput("reachX", int'(PixelX), tx);
    checkOutput("reachY", int'(PixelY), ty);
  endtask

  function automatic int expectedVector();
    bit hs, vs, vid;
    hs  = (mx >= HA + HF && mx < HA + HF + HS) ? POL : ~POL;
    vs  = (my >= VA + VF && my < VA + VF + VS) ? POL : ~POL;
    vid = (mx < HA) && (my < VA);
    return {mx[9:0], my[9:0], hs, vs, vid, expLine, expFrame};
  endfunction

  // Every cycle: whole output bundle against the coordinate model
  always @(negedge CLK) begin
    if (checkEn) begin
      checkOutput("model", int'({PixelX, PixelY, HSync, VSync, VideoOn, LineStart, FrameStart}),
                  expectedVector());
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int vidCount;
    int vLowCount;

    #1 RST = 1'b1;
    checkEn = 1'b1;
    for (int i = 0; i < 8; i++) applyStimulus(i % 4 == 0);
    checkOutput("resetX", int'(PixelX), 0);
    checkOutput("resetY", int'(PixelY), 0);
    checkOutput("resetVideoOn", int'(VideoOn), 1);
    checkOutput("resetHSync", int'(HSync), 1);
    checkOutput("resetVSync", int'(VSync), 1);
    checkOutput("resetStarts", int'({LineStart, FrameStart}), 0);
    RST = 1'b0;

    applyStimulus(1'b1);
    checkOutput("firstTickX", int'(PixelX), 1);
    checkOutput("firstTickHSync", int'(HSync), 1);
    checkOutput("firstTickVideoOn", int'(VideoOn), 1);

    advanceTo(15, 0);
    checkOutput("videoOnAt15", int'(VideoOn), 1);
    advanceTo(16, 0);
    checkOutput("videoOffAt16", int'(VideoOn), 0);
    advanceTo(19, 0);
    checkOutput("hsyncHighAt19", int'(HSync), 1);
    applyStimulus(1'b1);
    checkOutput("hsyncLowAt20", int'(HSync), 0);
    advanceTo(25, 0);
    checkOutput("hsyncLowAt25", int'(HSync), 0);
    advanceTo(26, 0);
    checkOutput("hsyncHighAt26", int'(HSync), 1);

    advanceTo(31, 0);
    applyStimulus(1'b1);
    checkOutput("lineWrapXY", int'({PixelX, PixelY}), 1);
    checkOutput("lineStartPulse", int'(LineStart), 1);
    checkOutput("frameStartQuiet", int'(FrameStart), 0);
    applyStimulus(1'b0);
    checkOutput("lineStartClears", int'(LineStart), 0);

    advanceTo(10, 1);
    for (int i = 0; i < 1000; i++) applyStimulus(1'b0);
    checkOutput("frozenX", int'(PixelX), 10);
    applyStimulus(1'b1);
    checkOutput("unfrozenX", int'(PixelX), 11);

    // One complete frame from (0,0) with random idle gaps between ticks
    advanceTo(0, 0);
    vidCount = 0;
    vLowCount = 0;
    lsCount = 0;
    fsCount = 0;
    for (int n = 0; n < HT * VT; n++) begin
      vidCount += int'(VideoOn);
      vLowCount += int'(!VSync);
      repeat ($urandom_range(0, 2)) applyStimulus(1'b0);
      applyStimulus(1'b1);
    end
    checkOutput("frameWrapXY", int'({PixelX, PixelY}), 0);
    checkOutput("frameWrapPulses", int'({LineStart, FrameStart}), 3);
    checkOutput("frameWrapVideoOn", int'(VideoOn), 1);
    checkOutput("videoTicks", vidCount, HA * VA);
    checkOutput("vsyncLowTicks", vLowCount, HT * VS);
    checkOutput("lineStarts", lsCount, VT);
    checkOutput("frameStarts", fsCount, 1);

    for (int i = 0; i < 200; i++) applyStimulus($urandom_range(0, 1) != 0);

    advanceTo(28, 15);
    checkOutput("vsyncLowBeforeReset", int'(VSync), 0);
    #1 RST = 1'b1;
    mx = 0;
    my = 0;
    expLine = 1'b0;
    expFrame = 1'b0;
    #1;
    checkOutput("asyncResetXY", int'({PixelX, PixelY}), 0);
    checkOutput("asyncResetSyncs", int'({HSync, VSync}), 3);
    checkOutput("asyncResetStarts", int'({LineStart, FrameStart}), 0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1);
    checkOutput("tickIgnoredInReset", int'(PixelX), 0);
    RST = 1'b0;
    applyStimulus(1'b1);
    checkOutput("firstTickAfterReset", int'(PixelX), 1);

    checkEn = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
